instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
IF stage of the 5-stage MIPS pipeline. Holds the PC and issues word reads to instruction memory over a req/ready port. Presents the fetched instruction and PC+4 to the IF/ID pipeline register. Handles downstream stall through a one-entry skid buffer, and handles branch/jump redirect with a flush of in-flight and buffered instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDR_W, 32, PC and imem address width

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
imem_req  out  1  read request to instruction memory
imem_addr  out  ADDR_W  word address of the request, equals PC
imem_ready  in  1  rdata valid this cycle for this cycle's imem_addr
imem_rdata  in  32  instruction word
stall  in  1  downstream (IF/ID, hazard unit) cannot accept
redirect  in  1  branch taken or jump: replace PC
redirect_target  in  ADDR_W  new PC
next_instruction  out  32  instruction to IF/ID
supposed_next_address  out  ADDR_W  fetched PC + 4
fetch_valid  out  1  next_instruction/supposed_next_address meaningful
fetch_misaligned  out  1  misaligned redirect flag (see Optional Feature)

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_PC; state=IDLE; skid empty.
  - next_instruction=0, supposed_next_address=0, fetch_valid=0, imem_req=0, fetch_misaligned=0.
- States: IDLE, FETCH, SKID.
- IDLE:
  - imem_req=0.
  - Unconditionally goes to FETCH next cycle. This gives one bubble after reset release.
  - A redirect in IDLE loads pc and still goes to FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc. Address is combinational from pc and may change while req is high.
  - imem_ready=0: hold state and pc.
  - imem_ready=1, redirect=0, slot free (fetch_valid=0 or stall=0): output regs load rdata and pc+4; fetch_valid=1; pc<=pc+4; stay in FETCH.
  - imem_ready=1, redirect=0, slot full (fetch_valid=1 and stall=1): skid loads rdata and pc+4; pc<=pc+4; go to SKID.
- SKID:
  - imem_req=0.
  - stall=0: output regs load skid contents; fetch_valid=1; skid empties; go to FETCH.
  - stall=1: hold everything.
- Consume rule: fetch_valid=1 and stall=0 at a clock edge means the output was taken. If no new word loads that edge, fetch_valid<=0 (bubble). next_instruction and supposed_next_address keep their values.
- Redirect (highest priority, any state, overrides stall and imem_ready):
  - pc<=redirect_target.
  - A response with imem_ready in the same cycle is discarded.
  - fetch_valid<=0; skid emptied; state<=FETCH (IDLE also goes to FETCH).
- Throughput: zero-wait memory (ready in the request cycle) with no stall gives one instruction per cycle. Latency from ready to fetch_valid is 1 cycle.
- Arithmetic: pc+4 wraps modulo 2^ADDR_W. 32'hFFFF_FFFC+4 = 0.
- A stall rising while a request is outstanding never loses a word: the skid absorbs it and no new request issues until the skid drains.
- Reset asserted mid-request: all state cleared immediately; the outstanding response is ignored.

Optional Feature:
FETCH_ALIGN_CHECK_EN
- Defined:
  - A redirect with target[1:0]!=0 sets fetch_misaligned=1 (sticky until reset), sets pc to the target, and moves to IDLE.
  - The FSM then stays in IDLE with imem_req=0 and fetch_valid=0 until reset.
- Not defined:
  - redirect_target[1:0] is forced to 2'b00 when loaded into pc.
  - fetch_misaligned is tied to 0.

Test Plan:
- Reset release, RESET_PC=0, imem_ready tied 1, instr=addr^32'hA5A5_0000 -> imem_req rises 1 cycle after release; outputs show (32'hA5A5_0000, 4), then (32'hA5A5_0004, 8), then (32'hA5A5_0008, 12); fetch_valid=1 every cycle.
- stall=1 for 3 cycles while ready=1 -> output frozen at the current word; next word held in skid; imem_req=0 during SKID. After stall drops, words resume in order with none lost or duplicated.
- redirect=1, target=32'h0000_0100, in the same cycle as imem_ready -> that response is dropped; fetch_valid=0 next cycle; next output is (mem[0x100], 32'h104).
- redirect while in SKID with stall=1 -> skid cleared; fetch_valid=0; first valid output is (mem[target], target+4).
- pc=32'hFFFF_FFFC, fetch -> supposed_next_address=0; next imem_addr=0.
- With FETCH_ALIGN_CHECK_EN defined, redirect to 32'h0000_0102 -> fetch_misaligned=1; imem_req stays 0 until reset. Without the macro -> next imem_addr=32'h0000_0100.

Source files
------------

// File: rtl/instruction_fetch.sv
// IF stage: PC, imem req/ready port, one-entry skid buffer, redirect flush.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned redirect targets.
module instruction_fetch #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [31:0]       next_instruction,
  output logic [ADDR_W-1:0] supposed_next_address,
  output logic              fetch_valid,
  output logic              fetch_misaligned
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SKID
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, pc_inc, tgt;
  logic [31:0]       skid_instr;
  logic [ADDR_W-1:0] skid_pc4;
  logic              valid_n;
  logic              load_out, load_skid, from_skid;
  logic              halt, bad;

  assign pc_inc    = pc + ADDR_W'(4);
  assign imem_addr = pc;

`ifdef FETCH_ALIGN_CHECK_EN
  assign tgt = redirect_target;
  assign bad = |redirect_target[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) halt <= 1'b0;
    else if (redirect && bad) halt <= 1'b1;
  end

  assign fetch_misaligned = halt;
`else
  assign tgt = redirect_target & ~ADDR_W'(3);
  assign bad = 1'b0;
  assign halt = 1'b0;
  assign fetch_misaligned = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    valid_n   = fetch_valid & stall;
    load_out  = 1'b0;
    load_skid = 1'b0;
    from_skid = 1'b0;
    imem_req  = (state == FETCH);
    if (halt) begin
      valid_n = 1'b0;
      state_n = IDLE;
    end else if (redirect) begin
      // same-cycle response is dropped; skid contents die with the state change
      pc_n    = tgt;
      valid_n = 1'b0;
      state_n = bad ? IDLE : FETCH;
    end else begin
      unique case (state)
        IDLE: state_n = FETCH;
        FETCH: begin
          if (imem_ready) begin
            pc_n = pc_inc;
            if (!fetch_valid || !stall) begin
              load_out = 1'b1;
              valid_n  = 1'b1;
            end else begin
              load_skid = 1'b1;
              state_n   = SKID;
            end
          end
        end
        SKID: begin
          if (!stall) begin
            load_out  = 1'b1;
            from_skid = 1'b1;
            valid_n   = 1'b1;
            state_n   = FETCH;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                 <= IDLE;
      pc                    <= RESET_PC;
      fetch_valid           <= 1'b0;
      next_instruction      <= '0;
      supposed_next_address <= '0;
      skid_instr            <= '0;
      skid_pc4              <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      fetch_valid <= valid_n;
      if (load_out) begin
        next_instruction      <= from_skid ? skid_instr : imem_rdata;
        supposed_next_address <= from_skid ? skid_pc4 : pc_inc;
      end
      if (load_skid) begin
        skid_instr <= imem_rdata;
        skid_pc4   <= pc_inc;
      end
    end
  end

endmodule
